req_arbiter_4: RTL and testbench

//  Four-requester arbiter for a shared resource, built on 4x2 priority-encode selection.

---
 rtl/req_arbiter_4.sv | 124 ++++++++++++
 tb/tb_req_arbiter_4.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with registered one-hot grant, encoded index and hold timeout.
// Define ROUND_ROBIN_EN to rotate priority away from the previous owner; default is fixed priority.
module req_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = MAX_HOLD[7:0];
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t     state, state_nx;
  logic [7:0] hold_cnt, hold_cnt_nx;
  logic [3:0] gnt_nx;
  logic [1:0] idx_nx;
  logic       timeout_nx;
  logic [1:0] win;

`ifdef ROUND_ROBIN_EN
  logic [1:0] last, last_nx;
  logic [1:0] start, cand;
  logic       found;

  // Scan downward from the slot just below the previous owner, wrapping.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    cand  = 2'd0;
    start = last - 2'd1;
    for (int i = 0; i < 4; i++) begin
      cand = start - 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    casez (req)
      4'b1???: win = 2'd3;
      4'b01??: win = 2'd2;
      4'b001?: win = 2'd1;
      default: win = 2'd0;
    endcase
  end
`endif

  // Next-state and next-output logic; ownership always ends in one IDLE cycle.
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    idx_nx      = gnt_idx;
    hold_cnt_nx = hold_cnt;
    timeout_nx  = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_nx     = last;
`endif
    case (state)
      IDLE: begin
        gnt_nx = 4'b0000;
        idx_nx = 2'd0;
        if (|req) begin
          state_nx    = GRANT;
          gnt_nx      = 4'b0001 << win;
          idx_nx      = win;
          hold_cnt_nx = 8'd1;
        end
      end
      GRANT: begin
        if (!req[gnt_idx] || (HOLD_EN && hold_cnt == HOLD_LIM)) begin
          state_nx    = IDLE;
          gnt_nx      = 4'b0000;
          idx_nx      = 2'd0;
          hold_cnt_nx = 8'd0;
          timeout_nx  = req[gnt_idx];
`ifdef ROUND_ROBIN_EN
          last_nx     = gnt_idx;
`endif
        end else if (hold_cnt != 8'hFF) begin
          hold_cnt_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
        idx_nx   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_idx  <= 2'd0;
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last     <= 2'd0;
`endif
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      gnt_idx  <= idx_nx;
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
`ifdef ROUND_ROBIN_EN
      last     <= last_nx;
`endif
    end
  end

  assign valid = |gnt;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Scoreboard bench for req_arbiter_4: a behavioural model predicts each cycle's outputs,
// which are queued at stimulus time and compared just after the following clock edge.
module tb_req_arbiter_4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       valid;
  logic       timeout;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  int   m_busy  = 0;
  int   m_owner = 0;
  int   m_cnt   = 0;
  int   m_last  = 0;
  logic m_to    = 1'b0;

  req_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner choice as described for the arbiter: highest index, or rotating away from last owner.
  function automatic int pickWinner(input logic [3:0] r, input int lst);
    int c;
`ifdef ROUND_ROBIN_EN
    for (int i = 1; i <= 4; i++) begin
      c = (lst + 4 - i) % 4;
      if (r[c]) return c;
    end
`else
    for (c = 3; c >= 0; c--)
      if (r[c]) return c;
`endif
    return 0;
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] rq);
    exp_t e;
    m_to = 1'b0;
    if (r) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_last = 0;
    end else if (m_busy == 0) begin
      if (rq != 4'b0000) begin
        m_owner = pickWinner(rq, m_last);
        m_busy  = 1;
        m_cnt   = 1;
      end
    end else if (!rq[m_owner]) begin
      m_busy = 0;
      m_last = m_owner;
    end else if (MH != 0 && m_cnt == MH) begin
      m_busy = 0;
      m_last = m_owner;
      m_to   = 1'b1;
    end else if (m_cnt < 255) begin
      m_cnt++;
    end
    e.gnt   = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = (m_busy != 0) ? 2'(m_owner) : 2'd0;
    e.valid = (m_busy != 0);
    e.to    = m_to;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = r;
      req = rq;
      modelStep(r, rq);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      cur = expq.pop_front();
      checkOutput("gnt",     {4'b0, gnt},     {4'b0, cur.gnt});
      checkOutput("gnt_idx", {6'b0, gnt_idx}, {6'b0, cur.idx});
      checkOutput("valid",   {7'b0, valid},   {7'b0, cur.valid});
      checkOutput("timeout", {7'b0, timeout}, {7'b0, cur.to});
    end
  end

  initial begin
    logic [3:0] rr;
    rst = 1'b1;
    req = 4'b0000;

    // Reset holds everything idle even with all requests up.
    applyStimulus(1'b1, 4'b1111, 2);

    // Grant to 2, release, one idle cycle, then grant to 0.
    applyStimulus(1'b0, 4'b0101, 2);
    applyStimulus(1'b0, 4'b0001, 3);
    applyStimulus(1'b0, 4'b0000, 2);

    // Continuous request: hold timeout, idle with pulse, regrant.
    applyStimulus(1'b0, 4'b1000, 12);
    applyStimulus(1'b0, 4'b0000, 2);

    // Drop on the last allowed cycle: release wins over timeout.
    applyStimulus(1'b0, 4'b0100, 4);
    applyStimulus(1'b0, 4'b0000, 2);

    // All requesting: fixed priority stays on 3, round robin rotates.
    applyStimulus(1'b0, 4'b1111, 16);
    applyStimulus(1'b0, 4'b0000, 2);

    // No preemption of owner 1 by a higher request.
    applyStimulus(1'b0, 4'b0010, 1);
    applyStimulus(1'b0, 4'b1010, 2);
    applyStimulus(1'b0, 4'b1000, 2);
    applyStimulus(1'b0, 4'b0000, 2);

    // Reset mid-grant, then arbitration restarts from reset priority.
    applyStimulus(1'b0, 4'b0100, 2);
    applyStimulus(1'b1, 4'b0100, 1);
    applyStimulus(1'b0, 4'b0110, 3);
    applyStimulus(1'b0, 4'b0000, 2);

    // Random traffic with sticky requests and occasional reset.
    rr = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) rr = 4'($urandom_range(15, 0));
      applyStimulus(($urandom_range(31, 0) == 0), rr, 1);
    end

    @(posedge clk);
    #2;
    checkOutput("queue_empty", 8'(expq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
